// File: rtl/nibble_serial_subtractor.sv
// 16-bit a-b, one 4-bit lookahead nibble per cycle; accept->out_valid 4 cycles, result held until out_ready.
// Optional signed flags (ovf, slt) enabled by defining SUB_SIGNED_FLAGS_EN.
module nibble_serial_subtractor (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] d,
   output logic        borrow,
   output logic        zero
`ifdef SUB_SIGNED_FLAGS_EN
   ,
   output logic        ovf,
   output logic        slt
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state_q, state_d;
   logic [15:0] a_q, a_d, b_q, b_d, d_q, d_d;
   logic [1:0]  nib_cnt_q, nib_cnt_d;
   logic        carry_q, carry_d;
   logic        out_valid_q, out_valid_d;
   logic        borrow_q, borrow_d;
   logic        zero_q, zero_d;
`ifdef SUB_SIGNED_FLAGS_EN
   logic        ovf_q, ovf_d;
   logic        slt_q, slt_d;
`endif

   logic [3:0]  a_nib, bn_nib, g, p, sum;
   logic [4:0]  c;

   // One shared 4-bit lookahead group; subtraction as a + ~b + 1 with the +1 injected at nibble 0.
   always_comb begin
      a_nib  = a_q[{nib_cnt_q, 2'b00} +: 4];
      bn_nib = ~b_q[{nib_cnt_q, 2'b00} +: 4];
      g      = a_nib & bn_nib;
      p      = a_nib | bn_nib;
      c[0]   = (nib_cnt_q == 2'd0) ? 1'b1 : carry_q;
      c[1]   = g[0] | (p[0] & c[0]);
      c[2]   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3]   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      c[4]   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
      sum    = a_nib ^ bn_nib ^ c[3:0];
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      d_d         = d_q;
      nib_cnt_d   = nib_cnt_q;
      carry_d     = carry_q;
      out_valid_d = out_valid_q;
      borrow_d    = borrow_q;
      zero_d      = zero_q;
`ifdef SUB_SIGNED_FLAGS_EN
      ovf_d       = ovf_q;
      slt_d       = slt_q;
`endif
      in_ready    = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d       = a;
               b_d       = b;
               nib_cnt_d = 2'd0;
               state_d   = RUN;
            end
         end
         RUN: begin
            d_d[{nib_cnt_q, 2'b00} +: 4] = sum;
            carry_d   = c[4];
            nib_cnt_d = nib_cnt_q + 2'd1;
            if (nib_cnt_q == 2'd3) begin
               // Flags are taken from the fully assembled difference, including this last nibble.
               state_d     = DONE;
               out_valid_d = 1'b1;
               borrow_d    = ~c[4];
               zero_d      = (d_d == 16'h0000);
`ifdef SUB_SIGNED_FLAGS_EN
               ovf_d       = (a_q[15] ^ b_q[15]) & (d_d[15] ^ a_q[15]);
               slt_d       = d_d[15] ^ ovf_d;
`endif
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= 16'h0000;
         b_q         <= 16'h0000;
         d_q         <= 16'h0000;
         nib_cnt_q   <= 2'd0;
         carry_q     <= 1'b0;
         out_valid_q <= 1'b0;
         borrow_q    <= 1'b0;
         zero_q      <= 1'b0;
`ifdef SUB_SIGNED_FLAGS_EN
         ovf_q       <= 1'b0;
         slt_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         d_q         <= d_d;
         nib_cnt_q   <= nib_cnt_d;
         carry_q     <= carry_d;
         out_valid_q <= out_valid_d;
         borrow_q    <= borrow_d;
         zero_q      <= zero_d;
`ifdef SUB_SIGNED_FLAGS_EN
         ovf_q       <= ovf_d;
         slt_q       <= slt_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign d         = d_q;
   assign borrow    = borrow_q;
   assign zero      = zero_q;
`ifdef SUB_SIGNED_FLAGS_EN
   assign ovf       = ovf_q;
   assign slt       = slt_q;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed bench for nibble_serial_subtractor; flag checks compile in with SUB_SIGNED_FLAGS_EN.
module tb_nibble_serial_subtractor;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = 16'h0000;
   logic [15:0] b = 16'h0000;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] d;
   logic        borrow;
   logic        zero;
`ifdef SUB_SIGNED_FLAGS_EN
   logic        ovf;
   logic        slt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   nibble_serial_subtractor dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .borrow    (borrow),
      .zero      (zero)
`ifdef SUB_SIGNED_FLAGS_EN
      ,
      .ovf       (ovf),
      .slt       (slt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Accepts one operand pair, measures latency, checks the result; returns at a negedge in DONE.
   task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic [15:0] ed, input logic eb, input logic ez);
      int n;
      @(negedge clk);
      in_valid = 1'b1;
      a = ta;
      b = tb_v;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = ~ta;
      b = ~tb_v;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!out_valid && n < 20);
      chk({tag, "_lat"}, n, 4);
      chk({tag, "_d"}, {16'h0, d}, {16'h0, ed});
      chk({tag, "_borrow"}, {31'h0, borrow}, {31'h0, eb});
      chk({tag, "_zero"}, {31'h0, zero}, {31'h0, ez});
      chk({tag, "_in_ready"}, {31'h0, in_ready}, 32'h0);
   endtask

   task automatic consume(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "_idle_rdy"}, {31'h0, in_ready}, 32'h1);
      chk({tag, "_idle_vld"}, {31'h0, out_valid}, 32'h0);
      out_ready = 1'b0;
   endtask

   initial begin
      #1 rst = 1'b1;
      #1;
      chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_d", {16'h0, d}, 32'h0);
      chk("rst_borrow", {31'h0, borrow}, 32'h0);
      chk("rst_zero", {31'h0, zero}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_op("basic", 16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0);
      consume("basic");
      run_op("under", 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
      consume("under");
      run_op("equal", 16'hABCD, 16'hABCD, 16'h0000, 1'b0, 1'b1);
      consume("equal");

      run_op("sgn1", 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0);
`ifdef SUB_SIGNED_FLAGS_EN
      chk("sgn1_ovf", {31'h0, ovf}, 32'h1);
      chk("sgn1_slt", {31'h0, slt}, 32'h1);
`endif
      consume("sgn1");
      run_op("sgn2", 16'h0001, 16'hFFFF, 16'h0002, 1'b1, 1'b0);
`ifdef SUB_SIGNED_FLAGS_EN
      chk("sgn2_ovf", {31'h0, ovf}, 32'h0);
      chk("sgn2_slt", {31'h0, slt}, 32'h0);
`endif
      consume("sgn2");

      // Backpressure: DONE held three cycles while a new pair is offered.
      run_op("bp", 16'h00FF, 16'h0010, 16'h00EF, 1'b0, 1'b0);
      in_valid = 1'b1;
      a = 16'h1111;
      b = 16'h2222;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_hold_vld", {31'h0, out_valid}, 32'h1);
         chk("bp_hold_rdy", {31'h0, in_ready}, 32'h0);
         chk("bp_hold_d", {16'h0, d}, 32'h000000EF);
         chk("bp_hold_borrow", {31'h0, borrow}, 32'h0);
         chk("bp_hold_zero", {31'h0, zero}, 32'h0);
      end
      in_valid = 1'b0;
      consume("bp");
      repeat (6) @(negedge clk);
      chk("bp_nocap_vld", {31'h0, out_valid}, 32'h0);
      chk("bp_nocap_rdy", {31'h0, in_ready}, 32'h1);
      chk("bp_keep_d", {16'h0, d}, 32'h000000EF);

      // Reset after nibble 1 is written; d is 16'h0010 at that point.
      @(negedge clk);
      in_valid = 1'b1;
      a = 16'h4321;
      b = 16'h1111;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("mid_d_pre", {16'h0, d}, 32'h00000010);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_rdy", {31'h0, in_ready}, 32'h1);
      chk("mid_rst_vld", {31'h0, out_valid}, 32'h0);
      chk("mid_rst_d", {16'h0, d}, 32'h0);
      chk("mid_rst_borrow", {31'h0, borrow}, 32'h0);
      chk("mid_rst_zero", {31'h0, zero}, 32'h0);
`ifdef SUB_SIGNED_FLAGS_EN
      chk("mid_rst_ovf", {31'h0, ovf}, 32'h0);
      chk("mid_rst_slt", {31'h0, slt}, 32'h0);
`endif
      @(negedge clk);
      rst = 1'b0;
      run_op("post", 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);
      consume("post");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
